bin_to_bcd_conv: RTL



---
 rtl/bcd_pkg.sv | 28 ++
 rtl/bcd_digit_adj.sv | 14 +
 rtl/bin_to_bcd_conv.sv | 127 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  // Largest decimal value representable in the given number of BCD digits.
  function automatic longint unsigned max_dec_value(input int digits);
    longint unsigned v;
    v = 1;
    for (int i = 0; i < digits; i++) v = v * 10;
    return v - 1;
  endfunction

  // Saturation word with every nibble set to 9 (up to 16 digits).
  function automatic logic [63:0] all_nines(input int digits);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < digits && i < 16; i++) v[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'h9;
    return v;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction cell: adds 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adj
);

  always_comb begin
    adj = digit;
    if (digit >= 4'd5) adj = digit + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_conv.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/done handshake.
// Optional macro SIGNED_INPUT_EN treats bin_in as two's complement and reports the sign on neg.
module bin_to_bcd_conv
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          ovf,
  output logic                          neg
);

  localparam int OUT_W = BCD_DIGIT_W * DIGITS;
  localparam int ACC_W = BCD_DIGIT_W * (DIGITS + 1);
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [OUT_W-1:0] SAT_VAL = OUT_W'(all_nines(DIGITS));

  conv_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [ACC_W-1:0] acc_q, acc_adj;
  logic [BIN_W-1:0] sr_q, mag;
  logic             lost_q;
  logic             done_q;
  logic [OUT_W-1:0] bcd_q;
  logic             ovf_q;
  logic             accept;
  logic             ovf_d;

  // The done cycle is spent in IDLE, so busy also covers it to block an accept there.
  assign busy    = (state_q != IDLE) || done_q;
  assign accept  = start && !busy;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;

  // A set bit in the guard digit, or one shifted out past it, means the value exceeds DIGITS digits.
  assign ovf_d = lost_q || (acc_q[ACC_W-1 -: BCD_DIGIT_W] != '0);

  for (genvar g = 0; g < DIGITS + 1; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adj   (acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

`ifdef SIGNED_INPUT_EN
  logic sign_q;
  logic neg_q;

  // Negation at BIN_W bits maps the most-negative value onto its unsigned magnitude.
  assign mag = bin_in[BIN_W-1] ? (~bin_in + 1'b1) : bin_in;
  assign neg = neg_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      if (accept) sign_q <= bin_in[BIN_W-1];
      if (state_q == DONE) neg_q <= sign_q;
    end
  end
`else
  assign mag = bin_in;
  assign neg = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no latch is inferred on unlisted paths.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the working registers are reset too, so an aborted conversion leaves no residue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      sr_q   <= '0;
      lost_q <= 1'b0;
      done_q <= 1'b0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (accept) begin
            sr_q   <= mag;
            acc_q  <= '0;
            cnt_q  <= CNT_W'(BIN_W - 1);
            lost_q <= 1'b0;
          end
        end
        SHIFT: begin
          {acc_q, sr_q} <= {acc_adj[ACC_W-2:0], sr_q, 1'b0};
          lost_q        <= lost_q | acc_adj[ACC_W-1];
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        DONE: begin
          bcd_q <= ovf_d ? SAT_VAL : acc_q[OUT_W-1:0];
          ovf_q <= ovf_d;
        end
        default: ;
      endcase
    end
  end

endmodule
